// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART types, oversampling constants and baud divider helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_MID = 8;
  localparam int SAMPLE_HI  = 9;

  // Clocks per oversample tick; shared with the transmit side.
  function automatic int os_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Show-ahead synchronous FIFO with a registered head output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_dout;
  logic [AW:0]      w_wr_next;
  logic [AW:0]      w_rd_next;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [WIDTH-1:0] w_head_next;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign w_wr_next = r_wr_ptr + {{AW{1'b0}}, w_push_ok};
  assign w_rd_next = r_rd_ptr + {{AW{1'b0}}, w_pop_ok};
  assign dout      = r_dout;

  // The new head bypasses memory when it is the word being written this cycle.
  always_comb begin
    w_head_next = r_dout;
    if (w_wr_next != w_rd_next) begin
      if (w_push_ok && (w_rd_next[AW-1:0] == r_wr_ptr[AW-1:0]))
        w_head_next = din;
      else
        w_head_next = r_mem[w_rd_next[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok)
      r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_dout   <= '0;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      r_dout   <= w_head_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_os16.sv
// ============================================================================
// Module   : uart_rx_os16
// Brief    : 16x oversampling UART receiver, majority vote, optional parity,
//            error pulses and a show-ahead receive FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] data_out,
  output logic       empty,
  output logic       full,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam int              OS_DIV   = os_div(CLK_FREQ, BAUD);
  localparam int              TICK_W   = $clog2(OS_DIV);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(OS_DIV - 1);

  uart_state_t       r_state;
  uart_state_t       w_state_next;
  logic              r_rx_meta;
  logic              r_rx_s;
  logic              r_rx_prev;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [3:0]        r_sample;
  logic              r_s_lo;
  logic              r_s_mid;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic              r_par_bad;
  logic              r_push;
  logic              r_ferr;
  logic              r_perr;

  logic w_tick;
  logic w_vote_tick;
  logic w_vote;
  logic w_par_exp;
  logic w_start;
  logic w_push_set;
  logic w_ferr_set;
  logic w_perr_set;

  assign w_tick      = (r_tick_cnt == TICK_MAX);
  assign w_vote_tick = w_tick && (r_sample == 4'(SAMPLE_HI));
  assign w_vote      = (r_s_lo & r_s_mid) | (r_s_lo & r_rx_s) | (r_s_mid & r_rx_s);
  assign w_par_exp   = (^r_shift) ^ (PARITY_ODD != 0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_push_set   = 1'b0;
    w_ferr_set   = 1'b0;
    w_perr_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_rx_prev && !r_rx_s) begin
          w_state_next = ST_START;
          w_start      = 1'b1;
        end
      end
      ST_START: begin
        if (w_vote_tick) w_state_next = w_vote ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (w_vote_tick && (r_bit_cnt == 3'd7))
          w_state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (w_vote_tick) w_state_next = ST_STOP;
      end
      ST_STOP: begin
        if (w_vote_tick) begin
          if (w_vote) begin
            w_state_next = ST_IDLE;
            w_perr_set   = r_par_bad;
            w_push_set   = !r_par_bad;
          end else begin
            w_ferr_set   = 1'b1;
            w_state_next = (r_shift == 8'h00) ? ST_BREAK : ST_IDLE;
          end
        end
      end
      ST_BREAK: begin
        if (r_rx_s) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta  <= 1'b1;
      r_rx_s     <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_tick_cnt <= '0;
      r_sample   <= '0;
      r_s_lo     <= 1'b1;
      r_s_mid    <= 1'b1;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_bad  <= 1'b0;
      r_push     <= 1'b0;
      r_ferr     <= 1'b0;
      r_perr     <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;

      // Realign the bit-period phase to the detected start edge.
      if (w_start || w_tick) r_tick_cnt <= '0;
      else                   r_tick_cnt <= r_tick_cnt + 1'b1;

      if (w_start)     r_sample <= '0;
      else if (w_tick) r_sample <= r_sample + 4'd1;

      if (w_tick && (r_sample == 4'(SAMPLE_LO)))  r_s_lo  <= r_rx_s;
      if (w_tick && (r_sample == 4'(SAMPLE_MID))) r_s_mid <= r_rx_s;

      if (w_start) begin
        r_bit_cnt <= '0;
        r_par_bad <= 1'b0;
      end else if (w_vote_tick && (r_state == ST_DATA)) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_shift   <= {w_vote, r_shift[7:1]};
      end else if (w_vote_tick && (r_state == ST_PARITY)) begin
        r_par_bad <= (w_vote != w_par_exp);
      end

      r_push <= w_push_set;
      r_ferr <= w_ferr_set;
      r_perr <= w_perr_set;
    end
  end

  assign frame_err  = r_ferr;
  assign parity_err = r_perr;
  assign overrun    = r_push & full;

  uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (r_push),
    .din     (r_shift),
    .pop     (rd_en),
    .dout    (data_out),
    .empty   (empty),
    .full    (full)
  );

endmodule

`default_nettype wire
